fetch_sequencer: RTL



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch front end.
// Imported by fetch_queue and fetch_sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      HALT
   } fetch_state_e;

   localparam logic [31:0] HALT_WORD = 32'h0000_0000;
   localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH x 32 synchronous FIFO with clear.
// Push and pop may coincide at any occupancy, including full.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [31:0]   wdata,
   input  logic          pop,
   input  logic          clear,
   output logic [31:0]   head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push)
                        - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, imem issue, fetch queue and Decode handshake.
// Optional FETCH_PERF_CNT_EN adds perf_issued / perf_stall counters.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int                QUEUE_DEPTH  = 2,
   parameter int                HALT_ON_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              imem_rd_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instruction,
   output logic              is_input_valid,
   input  logic              decode_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_stall,
`endif
   output logic              halted
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_e      state;
   logic [ADDR_W-1:0] pc;
   logic              in_flight;
   logic [CW-1:0]     q_count;
   logic [CW:0]       occ;
   logic              q_full;
   logic              q_empty;
   logic              q_push;
   logic              xfer;
   logic              zero_word;
   logic              zero_hit;
   logic              redirect_hit;
   logic              start_hit;

   assign xfer         = ~q_empty & decode_ready;
   assign redirect_hit = redirect_valid & (state != IDLE);
   assign start_hit    = start & ((state == IDLE) | (state == HALT));
   assign zero_word    = (HALT_ON_ZERO != 0) && (imem_rdata == HALT_WORD);
   assign zero_hit     = in_flight & zero_word & (state == RUN);
   assign q_push       = in_flight & ~redirect_hit & ~zero_word
                       & (~q_full | xfer);

   // a word leaving this cycle frees a slot, so issue can run back to back
   assign occ = {1'b0, q_count} + (CW+1)'(in_flight)
                                - (CW+1)'(xfer);

   assign imem_rd_en     = (state == RUN) &&
                           (occ < (CW+1)'(QUEUE_DEPTH));
   assign imem_addr      = pc;
   assign is_input_valid = ~q_empty;
   assign busy           = (state == RUN) | (state == DRAIN);
   assign halted         = (state == HALT);

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push),
      .wdata (imem_rdata),
      .pop   (xfer),
      .clear (redirect_hit),
      .head  (instruction),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         in_flight <= 1'b0;
      end else begin
         in_flight <= imem_rd_en & ~redirect_hit & ~zero_hit;
         if (imem_rd_en)
            pc <= pc + ADDR_W'(PC_STEP);
         if (redirect_hit) begin
            state <= RUN;
            pc    <= redirect_pc & ~ADDR_W'(3);
         end else if (zero_hit) begin
            state <= DRAIN;
         end else begin
            unique case (state)
               IDLE, HALT: begin
                  if (start) begin
                     state <= RUN;
                     pc    <= RESET_PC;
                  end
               end
               RUN: ;
               DRAIN: begin
                  if (q_empty && !in_flight)
                     state <= HALT;
               end
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else if (start_hit) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (xfer && perf_issued != '1)
            perf_issued <= perf_issued + 32'd1;
         if (!q_empty && !decode_ready && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`else
   logic unused_start_hit;
   assign unused_start_hit = start_hit;
`endif

endmodule
